// File: rtl/arb_pkg.sv
// Shared types and default widths for the arbiter requester agents.
package arb_pkg;

   localparam int ARB_DW    = 32;
   localparam int ARB_LW    = 4;
   localparam int ARB_DEPTH = 4;

   // Command as queued by an agent at the default widths.
   typedef struct packed {
      logic [ARB_DW-1:0] data;
      logic [ARB_LW-1:0] len;
   } cmd_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      BURST = 2'd2
   } agent_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with registered full/empty flags, so that anything
// derived from them is free of decode glitches.
module sync_fifo #(
   parameter int WIDTH = 36,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count_q;
   logic [AW:0]      count_nxt;
   logic             full_q;
   logic             empty_q;
   logic             do_push;
   logic             do_pop;

   // Push/pop are qualified against the registered flags; a pop never frees
   // a slot for a push in the same cycle.
   assign do_push = push & ~full_q;
   assign do_pop  = pop & ~empty_q;

   assign dout  = mem[rd_ptr];
   assign full  = full_q;
   assign empty = empty_q;
   assign count = count_q;

   // Occupancy after this cycle's push/pop.
   always_comb begin
      count_nxt = count_q;
      case ({do_push, do_pop})
         2'b10:   count_nxt = count_q + (AW+1)'(1);
         2'b01:   count_nxt = count_q - (AW+1)'(1);
         default: count_nxt = count_q;
      endcase
   end

   // Storage, pointers and flags; storage is cleared so the head reads zero out of reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) rd_ptr <= rd_ptr + AW'(1);
         count_q <= count_nxt;
         empty_q <= (count_nxt == '0);
         full_q  <= (count_nxt == (AW+1)'(DEPTH));
      end
   end

endmodule

// File: rtl/arb_req_agent.sv
// Requester-side agent: queues burst commands, requests its arbiter slot and
// streams the head command's beats to the shared target while granted.
//
//   state | meaning
//   IDLE  | FIFO empty, no request
//   REQ   | head command loaded, beat index 0
//   BURST | head command partly sent, beat index > 0
module arb_req_agent
   import arb_pkg::*;
#(
   parameter int DW    = ARB_DW,
   parameter int LW    = ARB_LW,
   parameter int DEPTH = ARB_DEPTH
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cmd_valid_i,
   output logic          cmd_ready_o,
   input  logic [DW-1:0] cmd_data_i,
   input  logic [LW-1:0] cmd_len_i,
   output logic          req_o,
   input  logic          gnt_i,
   output logic          beat_valid_o,
   output logic [DW-1:0] beat_data_o,
   output logic          beat_last_o,
   input  logic          tgt_ready_i,
   output logic          busy_o
);

   localparam int CW = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [LW-1:0] len;
   } entry_t;

   entry_t        push_ent;
   entry_t        head;
   logic          fifo_full;
   logic          fifo_empty;
   logic [CW-1:0] count;
   logic          push;
   logic          pop;
   logic          fire;
   logic          at_last;
   logic          more_after_pop;
   logic [LW-1:0] beat_cnt_q;
   logic [LW-1:0] beat_cnt_d;
   agent_state_e  state_q;
   agent_state_e  state_d;

   assign push_ent.data = cmd_data_i;
   assign push_ent.len  = cmd_len_i;

   sync_fifo #(
      .WIDTH ($bits(entry_t)),
      .DEPTH (DEPTH)
   ) u_cmd_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (push_ent),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (count)
   );

   // The arbiter's grant is combinational from req, so req is a straight
   // inversion of a flop output rather than a decode of the count.
   assign req_o       = ~fifo_empty;
   assign cmd_ready_o = ~fifo_full;
   assign push        = cmd_valid_i & ~fifo_full;

   assign beat_valid_o = req_o & gnt_i;
   assign fire         = beat_valid_o & tgt_ready_i;
   assign at_last      = (beat_cnt_q == head.len);
   assign beat_last_o  = beat_valid_o & at_last;
   assign beat_data_o  = head.data + DW'(beat_cnt_q);
   assign pop          = fire & at_last;
   assign busy_o       = (state_q != IDLE);

   // Another command will be at the head after this pop.
   assign more_after_pop = (count > CW'(1)) | push;

   // Next state and beat index.
   always_comb begin
      state_d    = state_q;
      beat_cnt_d = beat_cnt_q;
      case (state_q)
         IDLE: begin
            if (push) state_d = REQ;
         end
         REQ: begin
            if (fire) begin
               if (!at_last) begin
                  state_d    = BURST;
                  beat_cnt_d = beat_cnt_q + LW'(1);
               end else begin
                  state_d = more_after_pop ? REQ : IDLE;
               end
            end
         end
         BURST: begin
            if (fire) begin
               if (!at_last) begin
                  beat_cnt_d = beat_cnt_q + LW'(1);
               end else begin
                  beat_cnt_d = '0;
                  state_d    = more_after_pop ? REQ : IDLE;
               end
            end
         end
         default: begin
            state_d    = IDLE;
            beat_cnt_d = '0;
         end
      endcase
   end

   // State and beat index registers; reset drops any burst in progress.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

endmodule

// File: tb/tb_arb_req_agent.sv
// Bench for arb_req_agent: vector table of single-command bursts, scoreboard
// of expected beats, and hand sequences for full FIFO, back-to-back and reset.
module tb_arb_req_agent;
   import arb_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        cmd_valid_i = 1'b0;
   logic        cmd_ready_o;
   logic [31:0] cmd_data_i = '0;
   logic [3:0]  cmd_len_i = '0;
   logic        req_o;
   logic        gnt_i = 1'b0;
   logic        beat_valid_o;
   logic [31:0] beat_data_o;
   logic        beat_last_o;
   logic        tgt_ready_i = 1'b0;
   logic        busy_o;

   arb_req_agent #(.DW(32), .LW(4), .DEPTH(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .cmd_valid_i  (cmd_valid_i),
      .cmd_ready_o  (cmd_ready_o),
      .cmd_data_i   (cmd_data_i),
      .cmd_len_i    (cmd_len_i),
      .req_o        (req_o),
      .gnt_i        (gnt_i),
      .beat_valid_o (beat_valid_o),
      .beat_data_o  (beat_data_o),
      .beat_last_o  (beat_last_o),
      .tgt_ready_i  (tgt_ready_i),
      .busy_o       (busy_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] data;
      logic        last;
   } beat_t;

   typedef struct {
      logic [31:0] data;
      logic [3:0]  len;
      int          gap_after;
      int          gap_len;
      bit          gap_on_tgt;
      int          exp_cycles;
      logic [31:0] exp_last;
   } vec_t;

   beat_t       sb[$];
   beat_t       mon_e;
   logic [31:0] last_seen = '0;
   vec_t        vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: compare every fired beat against the scoreboard, then record
   // the expected beats of any command accepted at the coming edge.
   always @(negedge clk) begin
      if (reset && beat_valid_o && tgt_ready_i) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_unexpected_beat: got 0x%0h expected no beat", beat_data_o);
         end else begin
            mon_e = sb.pop_front();
            check("beat_data", beat_data_o, mon_e.data);
            check("beat_last", 32'(beat_last_o), 32'(mon_e.last));
         end
         if (beat_last_o) last_seen = beat_data_o;
      end
      if (reset && cmd_valid_i && cmd_ready_o) begin
         for (int i = 0; i <= int'(cmd_len_i); i++)
            sb.push_back('{cmd_data_i + 32'(i), (i == int'(cmd_len_i))});
      end
   end

   // Push one command with grant/ready high, then count request cycles,
   // optionally dropping grant or ready for a stretch mid-burst.
   task automatic run_vec(input vec_t v, input string tag);
      int cyc = 0;
      int fires = 0;
      int gap_rem = v.gap_len;
      last_seen   = 32'hDEAD_BEEF;
      gnt_i       = 1'b1;
      tgt_ready_i = 1'b1;
      cmd_valid_i = 1'b1;
      cmd_data_i  = v.data;
      cmd_len_i   = v.len;
      @(posedge clk);
      #1 cmd_valid_i = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (!req_o) break;
         cyc++;
         if (beat_valid_o && tgt_ready_i) fires++;
         @(posedge clk);
         #1;
         if (v.gap_len > 0 && fires == v.gap_after && gap_rem > 0) begin
            gap_rem--;
            if (v.gap_on_tgt) tgt_ready_i = 1'b0;
            else              gnt_i = 1'b0;
         end else begin
            gnt_i       = 1'b1;
            tgt_ready_i = 1'b1;
         end
      end
      check({tag, " req_cycles"}, 32'(cyc), 32'(v.exp_cycles));
      check({tag, " last_data"}, last_seen, v.exp_last);
      check({tag, " sb_drained"}, 32'(sb.size()), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int fires;
      bit got;

      vecs[0] = '{32'h0000_0100, 4'd3,  0, 0, 1'b0, 4,  32'h0000_0103};
      vecs[1] = '{32'h0000_0100, 4'd3,  2, 3, 1'b0, 7,  32'h0000_0103};
      vecs[2] = '{32'hFFFF_FFFE, 4'd2,  0, 0, 1'b0, 3,  32'h0000_0000};
      vecs[3] = '{32'h0000_0005, 4'd0,  0, 0, 1'b0, 1,  32'h0000_0005};
      vecs[4] = '{32'h0000_1234, 4'd15, 0, 0, 1'b0, 16, 32'h0000_1243};
      vecs[5] = '{32'h0000_0040, 4'd2,  1, 2, 1'b1, 5,  32'h0000_0042};

      // Reset values, with grant and ready already high.
      gnt_i       = 1'b1;
      tgt_ready_i = 1'b1;
      #12;
      check("rst req_o",        32'(req_o), 32'd0);
      check("rst cmd_ready_o",  32'(cmd_ready_o), 32'd1);
      check("rst beat_valid_o", 32'(beat_valid_o), 32'd0);
      check("rst beat_last_o",  32'(beat_last_o), 32'd0);
      check("rst busy_o",       32'(busy_o), 32'd0);
      check("rst beat_data_o",  beat_data_o, 32'd0);
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      check("gnt_without_req beat_valid", 32'(beat_valid_o), 32'd0);
      @(posedge clk);
      #1;

      for (int v = 0; v < 6; v++) run_vec(vecs[v], $sformatf("vec%0d", v));

      // Two len=0 commands back to back: adjacent single-beat bursts.
      cmd_valid_i = 1'b1;
      cmd_data_i  = 32'hA;
      cmd_len_i   = 4'd0;
      @(posedge clk);
      #1 cmd_data_i = 32'hB;
      @(negedge clk);
      check("b2b first data", beat_data_o, 32'hA);
      check("b2b first last", 32'(beat_valid_o & beat_last_o), 32'd1);
      @(posedge clk);
      #1 cmd_valid_i = 1'b0;
      @(negedge clk);
      check("b2b second data", beat_data_o, 32'hB);
      check("b2b second last", 32'(beat_valid_o & beat_last_o), 32'd1);
      @(negedge clk);
      check("b2b req_drop", 32'(req_o), 32'd0);
      @(posedge clk);
      #1;

      // Fill the FIFO without grant, then hold a fifth command until a pop.
      gnt_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cmd_valid_i = 1'b1;
         cmd_data_i  = 32'h300 + 32'(i * 16);
         cmd_len_i   = 4'd1;
         check($sformatf("fill ready_before_push%0d", i), 32'(cmd_ready_o), 32'd1);
         @(posedge clk);
         #1;
      end
      cmd_valid_i = 1'b0;
      check("full cmd_ready_o", 32'(cmd_ready_o), 32'd0);
      check("full busy_o",      32'(busy_o), 32'd1);
      check("full req_o",       32'(req_o), 32'd1);
      cmd_valid_i = 1'b1;
      cmd_data_i  = 32'h340;
      cmd_len_i   = 4'd0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("full hold_ready%0d", i), 32'(cmd_ready_o), 32'd0);
      end
      @(posedge clk);
      #1 gnt_i = 1'b1;
      fires = 0;
      got   = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (cmd_ready_o) begin
            got = 1'b1;
            break;
         end
         if (beat_valid_o && tgt_ready_i) fires++;
      end
      check("full ready_reopened",   32'(got), 32'd1);
      check("full fires_before_ready", 32'(fires), 32'd2);
      @(posedge clk);
      #1 cmd_valid_i = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (!req_o) begin
            got = 1'b1;
            break;
         end
      end
      check("full drained",    32'(got), 32'd1);
      check("full sb_drained", 32'(sb.size()), 32'd0);
      @(posedge clk);
      #1;

      // Reset in the middle of a 4-beat burst.
      cmd_valid_i = 1'b1;
      cmd_data_i  = 32'h500;
      cmd_len_i   = 4'd3;
      @(posedge clk);
      #1 cmd_valid_i = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #2 reset = 1'b0;
      sb.delete();
      #1;
      check("midrst req_o",        32'(req_o), 32'd0);
      check("midrst cmd_ready_o",  32'(cmd_ready_o), 32'd1);
      check("midrst beat_valid_o", 32'(beat_valid_o), 32'd0);
      check("midrst beat_last_o",  32'(beat_last_o), 32'd0);
      check("midrst busy_o",       32'(busy_o), 32'd0);
      check("midrst beat_data_o",  beat_data_o, 32'd0);
      @(posedge clk);
      #1 reset = 1'b1;
      cmd_valid_i = 1'b1;
      cmd_data_i  = 32'h600;
      cmd_len_i   = 4'd1;
      @(posedge clk);
      #1 cmd_valid_i = 1'b0;
      @(negedge clk);
      check("postrst first_beat", beat_data_o, 32'h600);
      check("postrst first_valid", 32'(beat_valid_o), 32'd1);
      @(negedge clk);
      check("postrst second_beat", beat_data_o, 32'h601);
      @(negedge clk);
      check("postrst req_drop", 32'(req_o), 32'd0);
      check("postrst sb_drained", 32'(sb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
